// File: rtl/eth_pkg.sv
// Shared types for the Ethernet receive frame reader: FSM states, EtherTypes,
// the skid-buffer word layout and the last-word byte-enable decode.
package eth_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      CLEAR
   } rx_state_t;

   // 37-bit skid entry: 32 data bits, last flag, 4 byte enables (bit 3 = byte 0)
   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [3:0]  keep;
   } rx_word_t;

   function automatic logic [3:0] keep_decode(input logic [1:0] len_mod);
      case (len_mod)
         2'd1:    return 4'b1000;
         2'd2:    return 4'b1100;
         2'd3:    return 4'b1110;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/eth_rx_skid.sv
// Two-entry output skid FIFO; decouples the one-clock FIFO read latency from
// downstream back-pressure.
module eth_rx_skid
   import eth_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  rx_word_t din,
   input  logic     pop,
   output rx_word_t dout,
   output logic [1:0] count
);

   rx_word_t mem [2];
   logic     wr_ptr;
   logic     rd_ptr;
   logic     push_ok;
   logic     pop_ok;

   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/eth_rx_frame_reader.sv
// Pulls complete frames out of the MAC receive FIFO, filters on EtherType and
// streams accepted frames as 32-bit words with last/keep sideband.
module eth_rx_frame_reader
   import eth_pkg::*;
#(
   parameter logic [15:0] PROTO_ACCEPT = ETH_TYPE_IPV4,
   parameter bit          FILTER_EN    = 1'b1,
   parameter int          CLEAR_CYCLES = 4
) (
   input  logic        clk_100_mhz,
   input  logic        rst,
   input  logic        rx_ready,
   input  logic        rx_empty,
   input  logic [15:0] rx_data_count,
   input  logic [15:0] rx_protocol_type,
   input  logic [31:0] rx_data,
   output logic        rx_read_en,
   output logic        rx_clear,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic [3:0]  m_keep,
   output logic        frame_start,
   output logic [15:0] frame_len,
   output logic [15:0] frame_proto,
   output logic [15:0] drop_count
);

   localparam int            CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

   rx_state_t     state, state_nxt;
   logic [16:0]   words_left;
   logic [16:0]   rx_words;
   logic [CW-1:0] clr_cnt;
   logic [1:0]    len_mod;
   logic          rd_vld;
   logic          rd_last;
   logic          rd_issue;
   logic          passes;
   logic          zero_len;
   logic          skid_pop;
   logic [1:0]    skid_cnt;
   logic [2:0]    occ_next;
   rx_word_t      skid_din;
   rx_word_t      skid_dout;

   always_comb begin
      rx_words = ({1'b0, rx_data_count} + 17'd3) >> 2;
      zero_len = (rx_data_count == 16'd0);
      passes   = !FILTER_EN || (rx_protocol_type == PROTO_ACCEPT);
   end

   assign m_valid  = (skid_cnt != 2'd0);
   assign skid_pop = m_valid && m_ready;
   assign m_data   = skid_dout.data;
   assign m_last   = m_valid && skid_dout.last;
   assign m_keep   = m_valid ? skid_dout.keep : 4'b0000;

   // Occupancy the skid will have once this clock's pop and returning read land;
   // counting the pop keeps reads flowing every clock under m_ready=1.
   assign occ_next = {1'b0, skid_cnt} + {2'b00, rd_vld} - {2'b00, skid_pop};

   always_comb begin
      skid_din.data = rx_data;
      skid_din.last = rd_last;
      skid_din.keep = rd_last ? keep_decode(len_mod) : 4'b1111;
   end

   eth_rx_skid u_skid (
      .clk   (clk_100_mhz),
      .rst   (rst),
      .push  (rd_vld),
      .din   (skid_din),
      .pop   (skid_pop),
      .dout  (skid_dout),
      .count (skid_cnt)
   );

   always_comb begin
      state_nxt   = state;
      rd_issue    = 1'b0;
      frame_start = 1'b0;
      rx_clear    = 1'b0;
      case (state)
         IDLE: begin
            if (rx_ready) begin
               if (zero_len) begin
                  state_nxt = CLEAR;
               end else if (passes) begin
                  state_nxt   = READ;
                  frame_start = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         READ: begin
            rd_issue = !rx_empty && (words_left != 17'd0) && (occ_next < 3'd2);
            if (skid_pop && skid_dout.last)
               state_nxt = CLEAR;
         end
         DRAIN: begin
            rd_issue = !rx_empty && (words_left != 17'd0);
            // once nothing is left to pop, the final read's data returns this clock
            if (words_left == 17'd0)
               state_nxt = CLEAR;
         end
         CLEAR: begin
            rx_clear = 1'b1;
            if (clr_cnt == CLR_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rx_read_en = rd_issue;

   always_ff @(posedge clk_100_mhz) begin
      if (rst) begin
         state       <= IDLE;
         words_left  <= 17'd0;
         rd_vld      <= 1'b0;
         rd_last     <= 1'b0;
         len_mod     <= 2'd0;
         clr_cnt     <= '0;
         frame_len   <= 16'd0;
         frame_proto <= 16'd0;
         drop_count  <= 16'd0;
      end else begin
         state   <= state_nxt;
         rd_vld  <= rd_issue && (state == READ);
         rd_last <= rd_issue && (words_left == 17'd1);
         if ((state == IDLE) && rx_ready) begin
            words_left <= rx_words;
            len_mod    <= rx_data_count[1:0];
            if (frame_start) begin
               frame_len   <= rx_data_count;
               frame_proto <= rx_protocol_type;
            end else if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end else if (rd_issue) begin
            words_left <= words_left - 17'd1;
         end
         clr_cnt <= ((state == CLEAR) && (state_nxt == CLEAR)) ? clr_cnt + CW'(1) : '0;
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_reader.sv
// Randomized bench for eth_rx_frame_reader: a queue-based receiver model feeds
// the DUT and a word scoreboard checks the output stream every clock.
module tb_eth_rx_frame_reader;

   localparam logic [15:0] IPV4 = 16'h0800;
   localparam logic [15:0] ARP  = 16'h0806;
   localparam int          CLR  = 4;

   logic        clk_100_mhz = 1'b0;
   logic        rst = 1'b1;
   logic        rx_ready = 1'b0;
   logic        rx_empty = 1'b1;
   logic [15:0] rx_data_count = 16'd0;
   logic [15:0] rx_protocol_type = 16'd0;
   logic [31:0] rx_data = 32'd0;
   logic        rx_read_en;
   logic        rx_clear;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic [3:0]  m_keep;
   logic        frame_start;
   logic [15:0] frame_len;
   logic [15:0] frame_proto;
   logic [15:0] drop_count;

   eth_rx_frame_reader #(
      .PROTO_ACCEPT (IPV4),
      .FILTER_EN    (1'b1),
      .CLEAR_CYCLES (CLR)
   ) dut (
      .clk_100_mhz      (clk_100_mhz),
      .rst              (rst),
      .rx_ready         (rx_ready),
      .rx_empty         (rx_empty),
      .rx_data_count    (rx_data_count),
      .rx_protocol_type (rx_protocol_type),
      .rx_data          (rx_data),
      .rx_read_en       (rx_read_en),
      .rx_clear         (rx_clear),
      .m_data           (m_data),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_last           (m_last),
      .m_keep           (m_keep),
      .frame_start      (frame_start),
      .frame_len        (frame_len),
      .frame_proto      (frame_proto),
      .drop_count       (drop_count)
   );

   always #5 clk_100_mhz = ~clk_100_mhz;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [3:0]  keep;
   } word_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // receiver and scoreboard state
   logic [31:0] rxq[$];
   word_t       exp_q[$];
   int          rdy_mode = 0;
   bit          empty_rand = 1'b0;
   bit          drop_active = 1'b0;
   bit          rd_ret = 1'b0;
   logic [31:0] ret_word = 32'd0;
   int          pops = 0, accepted = 0, clr_pulses = 0, clr_run = 0, fs_count = 0;
   int          cyc = 0, first_acc = -1, last_acc = 0;
   logic [3:0]  last_keep_seen = 4'd0;
   logic [15:0] exp_drop = 16'd0;
   bit          held = 1'b0;
   logic [36:0] held_w = '0;

   // receiver: drive at negedge, then sample what the DUT will see at the edge
   initial begin
      forever begin
         @(negedge clk_100_mhz);
         rx_data = rd_ret ? ret_word : $urandom;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         rx_empty = (rxq.size() == 0) || (empty_rand && ($urandom_range(0, 2) == 0));
         #1;
         rd_ret = 1'b0;
         if (rx_read_en && !rst) begin
            chk("read_while_empty", rx_empty, 1'b0);
            if (!rx_empty) begin
               ret_word = rxq.pop_front();
               rd_ret   = 1'b1;
               pops++;
            end
         end
      end
   end

   // compare process
   initial begin
      word_t w;
      forever begin
         @(negedge clk_100_mhz);
         #1;
         cyc++;
         if (rst) begin
            held    = 1'b0;
            clr_run = 0;
         end else begin
            if (held) begin
               chk("valid_held", m_valid, 1'b1);
               chk("stable", {m_data, m_last, m_keep}, held_w);
            end
            if (drop_active)
               chk("valid_in_drop", m_valid, 1'b0);
            if (m_valid && m_ready) begin
               chk("word_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  chk("m_data", m_data, w.data);
                  chk("m_last", m_last, w.last);
                  chk("m_keep", m_keep, w.keep);
               end
               accepted++;
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
               if (m_last) last_keep_seen = m_keep;
            end
            held   = m_valid && !m_ready;
            held_w = {m_data, m_last, m_keep};
            if (rx_clear) begin
               chk("read_in_clear", rx_read_en, 1'b0);
               clr_run++;
            end else if (clr_run > 0) begin
               chk("clear_width", clr_run, CLR);
               clr_pulses++;
               clr_run = 0;
            end
            if (frame_start) fs_count++;
         end
      end
   end

   task automatic load_frame(input int len, input logic [15:0] proto, output bit pass, output int nw);
      logic [31:0] d;
      logic [3:0]  kf;
      word_t       ew;
      int          rem;
      nw   = (len + 3) / 4;
      rem  = len % 4;
      pass = (proto == IPV4) && (len != 0);
      for (int i = 0; i < nw; i++) begin
         d = $urandom;
         rxq.push_back(d);
         if (pass) begin
            kf      = 4'hF;
            ew.data = d;
            ew.last = (i == nw - 1);
            ew.keep = ((i == nw - 1) && (rem != 0)) ? ~(kf >> rem) : kf;
            exp_q.push_back(ew);
         end
      end
      if (!pass && exp_drop != 16'hFFFF) exp_drop++;
   endtask

   task automatic run_frame(input int len, input logic [15:0] proto, input int rmode,
                            input bit erand, input bit chk_burst);
      int nw, p0, a0, c0, f0, budget;
      bit pass;
      load_frame(len, proto, pass, nw);
      rdy_mode    = rmode;
      empty_rand  = erand;
      drop_active = !pass;
      p0 = pops; a0 = accepted; c0 = clr_pulses; f0 = fs_count;
      first_acc = -1;
      @(negedge clk_100_mhz);
      rx_data_count    = len[15:0];
      rx_protocol_type = proto;
      rx_ready         = 1'b1;
      budget = 0;
      while (clr_pulses == c0 && budget < 4000) begin
         @(negedge clk_100_mhz);
         if (rx_clear) rx_ready = 1'b0;
         budget++;
      end
      chk("frame_done", budget < 4000, 1'b1);
      rx_ready    = 1'b0;
      drop_active = 1'b0;
      chk("frame_start_n", fs_count - f0, pass);
      chk("pops", pops - p0, nw);
      chk("words_out", accepted - a0, pass ? nw : 0);
      chk("exp_q_left", exp_q.size(), 0);
      chk("drop_count", drop_count, exp_drop);
      if (pass) begin
         chk("frame_len", frame_len, len[15:0]);
         chk("frame_proto", frame_proto, proto);
      end
      if (chk_burst) chk("burst_span", last_acc - first_acc, nw - 1);
      repeat (2) @(negedge clk_100_mhz);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_m_valid"}, m_valid, 1'b0);
      chk({tag, "_m_last"}, m_last, 1'b0);
      chk({tag, "_m_keep"}, m_keep, 4'd0);
      chk({tag, "_rd_en"}, rx_read_en, 1'b0);
      chk({tag, "_rx_clear"}, rx_clear, 1'b0);
      chk({tag, "_fstart"}, frame_start, 1'b0);
      chk({tag, "_flen"}, frame_len, 16'd0);
      chk({tag, "_fproto"}, frame_proto, 16'd0);
      chk({tag, "_drops"}, drop_count, 16'd0);
   endtask

   initial begin
      int  p0, a0, c0, budget, nw;
      bit  pass;
      logic [15:0] pr;
      repeat (3) @(negedge clk_100_mhz);
      #2;
      chk_reset_vals("reset");
      @(negedge clk_100_mhz);
      rst = 1'b0;
      repeat (2) @(negedge clk_100_mhz);

      run_frame(64, IPV4, 0, 1'b0, 1'b1);
      chk("keep64", last_keep_seen, 4'b1111);
      run_frame(61, IPV4, 0, 1'b0, 1'b1);
      chk("keep61", last_keep_seen, 4'b1000);
      p0 = pops;
      run_frame(64, ARP, 0, 1'b0, 1'b0);
      chk("arp_pops", pops - p0, 16);
      chk("arp_drops", drop_count, 16'd1);
      run_frame(37, IPV4, 1, 1'b1, 1'b0);
      run_frame(64, IPV4, 1, 1'b1, 1'b0);
      p0 = pops;
      run_frame(0, IPV4, 0, 1'b0, 1'b0);
      chk("zero_pops", pops - p0, 0);
      chk("zero_drops", drop_count, 16'd2);

      // reset after the fifth word of a 64-byte frame
      load_frame(64, IPV4, pass, nw);
      rdy_mode = 0; empty_rand = 1'b0;
      a0 = accepted; c0 = clr_pulses;
      @(negedge clk_100_mhz);
      rx_data_count = 16'd64; rx_protocol_type = IPV4; rx_ready = 1'b1;
      budget = 0;
      while (accepted - a0 < 5 && budget < 200) begin
         @(negedge clk_100_mhz);
         budget++;
      end
      chk("reset_reach_w5", budget < 200, 1'b1);
      rst = 1'b1; rx_ready = 1'b0;
      exp_q.delete();
      rxq.delete();
      exp_drop = 16'd0;
      @(negedge clk_100_mhz);
      #2;
      chk_reset_vals("midrst");
      @(negedge clk_100_mhz);
      rst = 1'b0;
      repeat (20) @(negedge clk_100_mhz);
      chk("no_clear_after_rst", clr_pulses - c0, 0);
      run_frame(64, IPV4, 0, 1'b0, 1'b1);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       pr = ARP;
            1:       pr = 16'($urandom);
            default: pr = IPV4;
         endcase
         run_frame(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100)), pr,
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
      $fatal(1);
   end

endmodule
